strand_select_arbiter: RTL and testbench

- Shares the single instruction-issue slot among NUM_STRANDS strand state machines.
- Each cycle it picks one requesting strand round-robin, returns a one-hot grant so that strand's FSM advances, and registers that strand's PC, instruction, vector lane and strided offset into the pipeline register feeding decode.
- Handles downstream stall (hold) and per-strand flush (kill a held instruction).

---
 rtl/strand_select_arbiter.sv | 121 ++++++++++++
 tb/tb_strand_select_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/strand_select_arbiter.sv
// Round-robin arbiter for the single instruction-issue slot shared by the strands.
// Grants one requesting strand per cycle and registers its fields into the decode pipeline register.
module strand_select_arbiter #(
  parameter int NUM_STRANDS = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_STRANDS-1:0]    issue_request_i,
  input  logic [32*NUM_STRANDS-1:0] pc_i,
  input  logic [32*NUM_STRANDS-1:0] instruction_i,
  input  logic [4*NUM_STRANDS-1:0]  reg_lane_select_i,
  input  logic [32*NUM_STRANDS-1:0] strided_offset_i,
  input  logic [NUM_STRANDS-1:0]    flush_i,
  input  logic                      stall_i,
  output logic [NUM_STRANDS-1:0]    grant_o,
  output logic                      valid_o,
  output logic [ID_WIDTH-1:0]       strand_id_o,
  output logic [31:0]               pc_o,
  output logic [31:0]               instruction_o,
  output logic [3:0]                reg_lane_select_o,
  output logic [31:0]               strided_offset_o
);

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] strand_id;
    logic [31:0]         pc;
    logic [31:0]         instruction;
    logic [3:0]          lane;
    logic [31:0]         offset;
  } out_reg_t;

  out_reg_t            out_q, out_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic [31:0] pc_arr     [NUM_STRANDS];
  logic [31:0] instr_arr  [NUM_STRANDS];
  logic [31:0] offset_arr [NUM_STRANDS];
  logic [3:0]  lane_arr   [NUM_STRANDS];

  for (genvar n = 0; n < NUM_STRANDS; n++) begin : g_unpack
    assign pc_arr[n]     = pc_i[32*n +: 32];
    assign instr_arr[n]  = instruction_i[32*n +: 32];
    assign offset_arr[n] = strided_offset_i[32*n +: 32];
    assign lane_arr[n]   = reg_lane_select_i[4*n +: 4];
  end

  // Round-robin search starting one past the last winner; the ID_WIDTH-bit
  // addition wraps naturally because NUM_STRANDS is a power of two.
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] cand;
  logic                grant_any;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_STRANDS; k++) begin
      cand = last_grant_q + ID_WIDTH'(k);
      if (!grant_any && issue_request_i[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    if (stall_i || !reset_n) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant_o = '0;
    if (grant_any) begin
      grant_o[grant_idx] = 1'b1;
    end
  end

  // Stall holds the entry (a flush of its owner only kills valid); otherwise
  // a grant loads the winner, and an idle cycle just drops valid.
  always_comb begin
    out_d        = out_q;
    last_grant_d = last_grant_q;
    if (stall_i) begin
      if (flush_i[out_q.strand_id]) begin
        out_d.valid = 1'b0;
      end
    end else if (grant_any) begin
      out_d.valid       = 1'b1;
      out_d.strand_id   = grant_idx;
      out_d.pc          = pc_arr[grant_idx];
      out_d.instruction = instr_arr[grant_idx];
      out_d.lane        = lane_arr[grant_idx];
      out_d.offset      = offset_arr[grant_idx];
      last_grant_d      = grant_idx;
    end else begin
      out_d.valid = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      last_grant_q <= ID_WIDTH'(NUM_STRANDS - 1);
    end else begin
      out_q        <= out_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign valid_o           = out_q.valid;
  assign strand_id_o       = out_q.strand_id;
  assign pc_o              = out_q.pc;
  assign instruction_o     = out_q.instruction;
  assign reg_lane_select_o = out_q.lane;
  assign strided_offset_o  = out_q.offset;

endmodule

// File: tb/tb_strand_select_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants and register contents from a
// behavioural round-robin model; a negedge monitor pops and compares.
module tb_strand_select_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   issue_request_i;
  logic [127:0] pc_i;
  logic [127:0] instruction_i;
  logic [15:0]  reg_lane_select_i;
  logic [127:0] strided_offset_i;
  logic [3:0]   flush_i;
  logic         stall_i;
  logic [3:0]   grant_o;
  logic         valid_o;
  logic [1:0]   strand_id_o;
  logic [31:0]  pc_o;
  logic [31:0]  instruction_o;
  logic [3:0]   reg_lane_select_o;
  logic [31:0]  strided_offset_o;

  strand_select_arbiter #(.NUM_STRANDS(4), .ID_WIDTH(2)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_request_i   (issue_request_i),
    .pc_i              (pc_i),
    .instruction_i     (instruction_i),
    .reg_lane_select_i (reg_lane_select_i),
    .strided_offset_i  (strided_offset_i),
    .flush_i           (flush_i),
    .stall_i           (stall_i),
    .grant_o           (grant_o),
    .valid_o           (valid_o),
    .strand_id_o       (strand_id_o),
    .pc_o              (pc_o),
    .instruction_o     (instruction_o),
    .reg_lane_select_o (reg_lane_select_o),
    .strided_offset_o  (strided_offset_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    int        id;
    bit [31:0] pc;
    bit [31:0] instr;
    bit [3:0]  lane;
    bit [31:0] off;
  } st_t;

  int        n_cmp = 0;
  int        n_err = 0;
  bit        mon_en = 1'b0;
  bit [3:0]  gq[$];
  st_t       sq[$];

  // Reference model state
  int  m_last;
  st_t m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx = (last + k) % 4;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 3;
    m_st   = '{valid: 1'b0, id: 0, pc: '0, instr: '0, lane: '0, off: '0};
  endtask

  task automatic drive(input logic [3:0] req, input logic st, input logic [3:0] fl);
    int       p;
    bit [3:0] g;
    @(posedge clk);
    #1;
    issue_request_i   = req;
    stall_i           = st;
    flush_i           = fl;
    pc_i              = {$urandom, $urandom, $urandom, $urandom};
    instruction_i     = {$urandom, $urandom, $urandom, $urandom};
    strided_offset_i  = {$urandom, $urandom, $urandom, $urandom};
    reg_lane_select_i = 16'($urandom);
    p = pick(req, m_last);
    g = (st || p < 0) ? 4'b0000 : (4'b0001 << p);
    gq.push_back(g);
    if (st) begin
      if (fl[m_st.id]) m_st.valid = 1'b0;
    end else if (p >= 0) begin
      m_st.valid = 1'b1;
      m_st.id    = p;
      m_st.pc    = pc_i[32*p +: 32];
      m_st.instr = instruction_i[32*p +: 32];
      m_st.off   = strided_offset_i[32*p +: 32];
      m_st.lane  = reg_lane_select_i[4*p +: 4];
      m_last     = p;
    end else begin
      m_st.valid = 1'b0;
    end
    sq.push_back(m_st);
  endtask

  // Monitor: grant is compared against this cycle's inputs, registered
  // outputs against the state expected after the previous edge.
  initial begin
    bit [3:0] g;
    st_t      s;
    forever begin
      @(negedge clk);
      if (mon_en && gq.size() > 0) begin
        g = gq.pop_front();
        check("grant_o", 32'(grant_o), 32'(g));
        if (sq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard: no expected register state queued at %0t", $time);
        end else begin
          s = sq.pop_front();
          check("valid_o", 32'(valid_o), 32'(s.valid));
          if (s.valid) begin
            check("strand_id_o", 32'(strand_id_o), 32'(s.id));
            check("pc_o", pc_o, s.pc);
            check("instruction_o", instruction_o, s.instr);
            check("reg_lane_select_o", 32'(reg_lane_select_o), 32'(s.lane));
            check("strided_offset_o", strided_offset_o, s.off);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic restart_scoreboard();
    gq.delete();
    sq.delete();
    model_reset();
    sq.push_back(m_st);
  endtask

  initial begin
    reset_n = 1'b0;
    issue_request_i = '0; stall_i = 1'b0; flush_i = '0;
    pc_i = '0; instruction_i = '0; reg_lane_select_i = '0; strided_offset_i = '0;
    #23;
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset strand_id_o", 32'(strand_id_o), 32'd0);
    check("reset pc_o", pc_o, 32'd0);
    issue_request_i = 4'b1111;
    #1;
    check("grant_o during reset", 32'(grant_o), 32'd0);
    issue_request_i = '0;
    restart_scoreboard();
    @(posedge clk); #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Full rotation with everyone requesting
    repeat (8) drive(4'b1111, 1'b0, 4'b0000);
    // Bring last_grant to 1, then alternate 3/1
    drive(4'b0001, 1'b0, 4'b0000);
    drive(4'b0010, 1'b0, 4'b0000);
    repeat (4) drive(4'b1010, 1'b0, 4'b0000);
    // Strand 2 held across a stall; release resumes at strand 3
    drive(4'b0100, 1'b0, 4'b0000);
    repeat (3) drive(4'b1111, 1'b1, 4'b0000);
    drive(4'b1111, 1'b0, 4'b0000);
    // Flush of the held owner during stall, then flush of another strand
    drive(4'b0010, 1'b0, 4'b0000);
    drive(4'b0000, 1'b1, 4'b0010);
    drive(4'b0000, 1'b1, 4'b0000);
    drive(4'b0010, 1'b0, 4'b0000);
    drive(4'b0000, 1'b1, 4'b0100);
    drive(4'b0000, 1'b1, 4'b0000);
    // Idle after strand 3, then wrap to strand 0
    drive(4'b1000, 1'b0, 4'b0000);
    repeat (2) drive(4'b0000, 1'b0, 4'b0000);
    drive(4'b1001, 1'b0, 4'b0000);
    repeat (2) drive(4'b1111, 1'b0, 4'b0000);

    // Asynchronous reset mid-cycle while an entry is live
    @(posedge clk);
    #3;
    check("pre-reset valid_o", 32'(valid_o), 32'(m_st.valid));
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async reset valid_o", 32'(valid_o), 32'd0);
    check("async reset grant_o", 32'(grant_o), 32'd0);
    check("async reset pc_o", pc_o, 32'd0);
    restart_scoreboard();
    @(posedge clk); #2;
    issue_request_i = '0; stall_i = 1'b0; flush_i = '0;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (5) drive(4'b1111, 1'b0, 4'b0000);

    // Randomized traffic with stalls and flushes
    for (int i = 0; i < 400; i++) begin
      logic [3:0] req;
      logic       st;
      logic [3:0] fl;
      req = 4'($urandom);
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      drive(req, st, fl);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
